gray_code_stream_converter: RTL and testbench

//  Parametrised, clocked successor to the 4-bit combinational code decoder.

---
 rtl/gray_code_stream_converter.sv | 141 ++++++++++++++
 tb/tb_gray_code_stream_converter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gray_code_stream_converter.sv
// Streaming binary<->Gray converter with a DEPTH-entry result FIFO and an accepted-word counter.
// Optional CHECK_ADJ_EN build adds a sticky Gray-adjacency error check (seq_err).
module gray_code_stream_converter #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic [CNT_W-1:0] word_count,
    output logic             seq_err
);
    localparam int AW = $clog2(DEPTH);

    // Handshake: a word moves on a port only in a cycle where its valid and ready are both 1.
    // in_ready depends on registered occupancy only, never on out_ready.

    logic [WIDTH:0]     r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_mode;
    logic [CNT_W-1:0]   r_word_count;

    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_pop;
    logic [WIDTH-1:0]   w_gray;
    logic [WIDTH-1:0]   w_bin;
    logic [WIDTH:0]     w_entry;
    logic [AW:0]        w_count_next;
    logic [AW-1:0]      w_head_idx;
    logic               w_head_from_in;

    assign w_full   = (r_count == (AW+1)'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_accept = in_valid && !w_full;
    assign w_pop    = out_ready && !w_empty;

    always_comb begin : conv
        logic v_acc;
        w_gray = in_data ^ (in_data >> 1);
        v_acc  = in_data[WIDTH-1];
        w_bin  = '0;
        w_bin[WIDTH-1] = v_acc;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            v_acc    = v_acc ^ in_data[i];
            w_bin[i] = v_acc;
        end
    end

    assign w_entry = {in_mode, (in_mode ? w_bin : w_gray)};

    always_comb begin
        w_count_next = r_count;
        case ({w_accept, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // The next head is the word being written this edge when it lands in the slot the read pointer moves to.
    assign w_head_idx     = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
    assign w_head_from_in = w_accept && (r_wr_ptr == w_head_idx);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_out_data   <= '0;
            r_out_mode   <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_accept) begin
                r_wr_ptr     <= r_wr_ptr + 1'b1;
                r_word_count <= r_word_count + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_count_next != '0) begin
                if (w_head_from_in) begin
                    {r_out_mode, r_out_data} <= w_entry;
                end else begin
                    {r_out_mode, r_out_data} <= r_mem[w_head_idx];
                end
            end
        end
    end

    assign in_ready   = !w_full;
    assign out_valid  = !w_empty;
    assign out_data   = r_out_data;
    assign out_mode   = r_out_mode;
    assign word_count = r_word_count;

`ifdef CHECK_ADJ_EN
    logic [WIDTH-1:0] r_prev;
    logic             r_prev_valid;
    logic             r_seq_err;

    // Only Gray-mode words take part; the first one after reset just seeds r_prev.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_seq_err    <= 1'b0;
        end else if (w_accept && in_mode) begin
            r_prev       <= in_data;
            r_prev_valid <= 1'b1;
            if (r_prev_valid && ($countones(in_data ^ r_prev) != 1)) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    assign seq_err = r_seq_err;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_code_stream_converter.sv
// Bench for gray_code_stream_converter (WIDTH=4, DEPTH=4): directed steps then random traffic,
// all outputs compared each cycle against a queue-based reference model.
module tb_gray_code_stream_converter;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_mode;
  logic [CNT_W-1:0] word_count;
  logic             seq_err;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [WIDTH:0]   exp_q[$];
  int               m_wc;
  logic [WIDTH-1:0] m_out;
  logic             m_mode;
  logic             m_err;
  logic             m_prev_valid;
  logic [WIDTH-1:0] m_prev;

  gray_code_stream_converter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
    .word_count(word_count), .seq_err(seq_err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // binary bit i is the parity of all Gray bits at or above i
  function automatic logic [WIDTH-1:0] to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] s;
    for (int i = 0; i < WIDTH; i++) begin
      s = g >> i;
      r[i] = ^s;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_wc = 0;
    m_out = '0;
    m_mode = 1'b0;
    m_err = 1'b0;
    m_prev_valid = 1'b0;
    m_prev = '0;
  endtask

  task automatic check_all();
    chk("in_ready",   32'(in_ready),   32'(exp_q.size() < DEPTH));
    chk("out_valid",  32'(out_valid),  32'(exp_q.size() > 0));
    chk("out_data",   32'(out_data),   32'(m_out));
    chk("out_mode",   32'(out_mode),   32'(m_mode));
    chk("word_count", 32'(word_count), 32'(m_wc & 32'hFFFF));
`ifdef CHECK_ADJ_EN
    chk("seq_err",    32'(seq_err),    32'(m_err));
`else
    chk("seq_err",    32'(seq_err),    32'd0);
`endif
  endtask

  // driver task: one clock with the given inputs, then update model and compare
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic m,
                       input logic ordy, input logic r);
    logic acc;
    logic pop;
    logic [WIDTH-1:0] res;
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    out_ready = ordy;
    rst       = r;
    acc = !r && v && (exp_q.size() < DEPTH);
    pop = !r && ordy && (exp_q.size() > 0);
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        res = m ? to_bin(d) : to_gray(d);
        exp_q.push_back({m, res});
        m_wc++;
        if (m) begin
          if (m_prev_valid && ($countones(d ^ m_prev) != 1)) m_err = 1'b1;
          m_prev = d;
          m_prev_valid = 1'b1;
        end
      end
      if (exp_q.size() > 0) {m_mode, m_out} = exp_q[0];
    end
    check_all();
  endtask

  initial begin
    model_reset();

    // 1. reset for two cycles
    cycle(0, 4'h0, 0, 0, 1);
    cycle(0, 4'h0, 0, 0, 1);
    chk("t1_out_data", 32'(out_data), 32'd0);

    // 2. binary -> Gray
    cycle(1, 4'b0110, 0, 1, 0);
    chk("t2_out_data", 32'(out_data), 32'b0101);

    // 3. Gray -> binary, back to back
    cycle(1, 4'b1101, 1, 1, 0);
    chk("t3a_out_data", 32'(out_data), 32'b1001);
    cycle(1, 4'b1000, 1, 1, 0);
    chk("t3b_out_data", 32'(out_data), 32'b1111);
    cycle(0, 4'h0, 0, 1, 0);

    // 4. fill to full, hold off the fifth word, then drain
    cycle(0, 4'h0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) cycle(1, 4'(i), 0, 0, 0);
    chk("t4_full_in_ready", 32'(in_ready), 32'd0);
    cycle(1, 4'd5, 0, 0, 0);
    chk("t4_held_count", 32'(word_count), 32'd4);
    chk("t4_head", 32'(out_data), 32'b0001);
    cycle(1, 4'd5, 0, 1, 0);
    chk("t4_head2", 32'(out_data), 32'b0011);
    cycle(1, 4'd5, 0, 1, 0);
    chk("t4_count5", 32'(word_count), 32'd5);
    chk("t4_head3", 32'(out_data), 32'b0010);
    cycle(0, 4'h0, 0, 1, 0);
    chk("t4_head4", 32'(out_data), 32'b0110);
    for (int i = 0; i < 3; i++) cycle(0, 4'h0, 0, 1, 0);

    // 5. reset with words buffered
    cycle(1, 4'd9, 0, 0, 0);
    cycle(1, 4'd10, 1, 0, 0);
    cycle(0, 4'h0, 0, 1, 1);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_word_count", 32'(word_count), 32'd0);
    chk("t5_out_data", 32'(out_data), 32'd0);
    cycle(0, 4'h0, 0, 1, 0);

    // 6. Gray adjacency sequence
    cycle(1, 4'b0000, 1, 1, 0);
    cycle(1, 4'b0001, 1, 1, 0);
    chk("t6_no_err", 32'(seq_err), 32'd0);
    cycle(1, 4'b0111, 1, 1, 0);
    cycle(0, 4'h0, 0, 1, 0);
`ifdef CHECK_ADJ_EN
    chk("t6_err_sticky", 32'(seq_err), 32'd1);
`else
    chk("t6_err_absent", 32'(seq_err), 32'd0);
`endif

    // random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 59) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
